// File: rtl/uart_frame_rx_pkg.sv
// Shared types and helpers for the UART frame decoder: FSM state encoding,
// default sync marker and the running checksum step.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHECK,
    DRAIN
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-stream bundle around the frame decoder: inbound bytes from uart_rx and
// outbound payload beats. slave = decoder side, master = its environment.
interface uart_frame_rx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/uart_frame_rx_buf.sv
// Payload store: register array with one synchronous write port and one
// asynchronous read port. Contents are not reset; only validated frames are read.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder: SYNC, LEN, payload, XOR checksum; replays good payloads.
// Optional inter-byte timeout is built only with UART_FRAME_RX_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  uart_frame_rx_if.slave bus,
  output logic           frame_ok,
  output logic           frame_err,
  output logic [7:0]     err_count
);

  localparam int PW = $clog2(MAX_LEN) + 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (!(MAX_LEN >= 1 && MAX_LEN <= 255 && TIMEOUT_CYCLES >= 1)) begin : g_bad_cfg
    $error("uart_frame_rx: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;

  logic          in_fire, out_fire;
  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic          last_wr, last_rd, len_bad, tmo;

  assign bus.in_ready  = (state_q != DRAIN);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = bus.out_valid ? buf_rdata : 8'h00;
  assign bus.out_last  = bus.out_valid && last_rd;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  // len_q is never 0 outside IDLE/LEN, so len_q-1 is the index of the final byte
  assign last_wr = (wr_q == PW'(len_q - 8'd1));
  assign last_rd = (rd_q == PW'(len_q - 8'd1));
  assign len_bad = (bus.in_data == 8'h00) || (32'(bus.in_data) > MAX_LEN);

`ifdef UART_FRAME_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  // Counts idle cycles mid-frame only; DRAIN stalls are the consumer's business.
  always_comb begin
    tcnt_d = '0;
    tmo    = 1'b0;
    if ((state_q == LEN || state_q == PAYLOAD || state_q == CHECK) && !in_fire) begin
      if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) tmo = 1'b1;
      else                                   tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    csum_d      = csum_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    buf_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_fire && bus.in_data == SYNC_BYTE) state_d = LEN;
      end
      LEN: begin
        if (in_fire) begin
          if (len_bad) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            len_d   = bus.in_data;
            csum_d  = bus.in_data;
            wr_d    = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (in_fire) begin
          buf_we = 1'b1;
          csum_d = csum_next(csum_q, bus.in_data);
          wr_d   = wr_q + 1'b1;
          if (last_wr) state_d = CHECK;
        end
      end
      CHECK: begin
        if (in_fire) begin
          if (bus.in_data == csum_q) begin
            frame_ok_d = 1'b1;
            rd_d       = '0;
            state_d    = DRAIN;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          rd_d = rd_q + 1'b1;
          if (last_rd) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tmo only fires on cycles with no accepted byte, so it never races a decision above
    if (tmo) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end

    err_count_d = (frame_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      csum_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_q[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (rd_q[AW-1:0]),
    .rdata (buf_rdata)
  );

endmodule
